uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin scheduler that shares one uart_byte_tx instance among N_REQ byte producers.
- Accepts one byte per grant via a valid/ready handshake and latches that requester's byte and baud code.
- Fires a single-cycle en_send to uart_byte_tx, holds data_byte/set_baud stable until tx_done, then enforces an inter-byte gap.
- Sits between the application producers and uart_byte_tx; watchdog recovers from a missing tx_done.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYC, 16, idle clocks between tx_done and next grant (>=1)
TO_W, 20, watchdog counter width; timeout at 2^TO_W-1 clocks in WAIT

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  requester i has a byte pending
req_data  input  8*N_REQ  byte of requester i at [8i+7:8i]
req_baud  input  3*N_REQ  set_baud code of requester i at [3i+2:3i]
req_ready  output  N_REQ  one-hot, 1-cycle pulse: byte of requester i accepted this cycle
data_byte  output  8  to uart_byte_tx data_byte
set_baud  output  3  to uart_byte_tx set_baud
en_send  output  1  to uart_byte_tx en_send, 1-cycle pulse
tx_done  input  1  from uart_byte_tx
uart_state  input  1  from uart_byte_tx, 1 = transmitting
busy  output  1  arbiter not in IDLE
grant_id  output  3  index of requester currently owning the UART
done_pulse  output  1  1-cycle pulse when the granted byte completes
err_timeout  output  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0, en_send=0, busy=0, done_pulse=0, err_timeout=0, data_byte=8'h00, set_baud=3'd0, grant_id=0; RR pointer=0; counters=0.
- All outputs registered. Reset may assert in any state: abandon the transfer immediately with no done_pulse or error.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - if any req_valid, grant the first set bit scanning from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - Same edge: latch data_byte/set_baud from the granted slice, set grant_id, pulse req_ready[g], set ptr=(g+1) mod N_REQ, go ISSUE.
  - If uart_state=1 in IDLE (foreign activity), do not grant; stay IDLE.
- ISSUE: en_send=1 for exactly this one cycle; go WAIT; clear watchdog.
- WAIT:
  - en_send=0; data_byte/set_baud/grant_id held.
  - tx_done=1 -> done_pulse=1 next cycle, go GAP.
  - Watchdog increments each WAIT cycle; on reaching 2^TO_W-1 with no tx_done -> err_timeout=1 for one cycle, go GAP.
- GAP: count GAP_CYC cycles, then IDLE; tx_done during GAP ignored.
- tx_done outside WAIT is ignored.
- Requester protocol:
  - req_valid may rise at any time; the requester must hold req_data/req_baud stable while valid and not yet accepted.
  - Dropping valid before req_ready is allowed (request withdrawn, nothing sent).
- Latency: req_valid high in IDLE -> req_ready at next edge -> en_send one cycle later. Minimum byte-to-byte grant spacing = UART frame time + GAP_CYC + 2.
- Fairness: with all valid continuously, grants cycle 0,1,2,3,0,...; no requester is starved beyond N_REQ-1 other grants.
- busy=1 in ISSUE, WAIT and GAP.

Test Plan:
- Single requester: N_REQ=4, req_valid=4'b0100, data 8'h0F, baud 3'd0 -> req_ready=4'b0100 once, grant_id=2, en_send single pulse, data_byte=8'h0F and set_baud=0 stable to tx_done, done_pulse one cycle after tx_done, next grant after GAP_CYC=16 idle cycles.
- All four valid continuously, bytes 8'hA0..8'hA3 -> transmit order A0,A1,A2,A3,A0; each req_ready pulses exactly once per grant.
- Per-requester baud: req0 baud 1 byte 8'hAA, req1 baud 2 byte 8'hEE -> set_baud=1 during first frame and 2 during second; the uart_byte_tx model decodes 8'hAA then 8'hEE.
- Timeout: TO_W=6, model never asserts tx_done -> err_timeout pulses 63 cycles after entering WAIT, no done_pulse, arbiter returns to IDLE and grants the next requester.
- Reset mid-WAIT: drop rst_n for 3 cycles during a frame -> all outputs return to reset values asynchronously, ptr=0; after release req_valid=4'b1000 grants requester 3.
- Stray tx_done pulse during IDLE and GAP -> no done_pulse, no state change; withdrawn req_valid before grant -> no req_ready and no en_send.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte handshake bundle for uart_tx_arb: one valid/ready pair
// per producer plus that producer's packed byte and baud code.
`timescale 1ns/1ps
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [3*N_REQ-1:0] req_baud;
    logic [N_REQ-1:0]   req_ready;

    modport master (output req_valid, req_data, req_baud, input req_ready);
    modport slave  (input req_valid, req_data, req_baud, output req_ready);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_byte_tx among N_REQ byte producers,
// with a post-frame idle gap and a watchdog for a missing tx_done.
`timescale 1ns/1ps
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 16,
    parameter int TO_W    = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_arb_if.slave req_if,
    output logic [7:0]   data_byte,
    output logic [2:0]   set_baud,
    output logic         en_send,
    input  logic         tx_done,
    input  logic         uart_state,
    output logic         busy,
    output logic [2:0]   grant_id,
    output logic         done_pulse,
    output logic         err_timeout
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TO_W-1:0]  WD_MAX   = '1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [7:0]         data_byte_q, data_byte_d;
    logic [2:0]         set_baud_q, set_baud_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic               en_send_q, en_send_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               found;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic [7:0]         sel_data;
    logic [2:0]         sel_baud;
    int                 scan_idx;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        sel_data  = 8'h00;
        sel_baud  = 3'd0;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % N_REQ;
            cand     = PTR_W'(scan_idx);
            if (!found && req_if.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
                sel_data  = req_if.req_data[cand*8 +: 8];
                sel_baud  = req_if.req_baud[cand*3 +: 3];
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        data_byte_d = data_byte_q;
        set_baud_d  = set_baud_q;
        grant_id_d  = grant_id_q;
        req_ready_d = '0;
        en_send_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // A transmitter already busy on someone else's behalf blocks granting.
                if (found && !uart_state) begin
                    req_ready_d[grant_idx] = 1'b1;
                    data_byte_d = sel_data;
                    set_baud_d  = sel_baud;
                    grant_id_d  = 3'(grant_idx);
                    ptr_d       = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                en_send_d = 1'b1;
                wd_d      = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_MAX) begin
                        err_d   = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            req_ready_q <= '0;
            data_byte_q <= 8'h00;
            set_baud_q  <= 3'd0;
            grant_id_q  <= 3'd0;
            en_send_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            req_ready_q <= req_ready_d;
            data_byte_q <= data_byte_d;
            set_baud_q  <= set_baud_d;
            grant_id_q  <= grant_id_d;
            en_send_q   <= en_send_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_if.req_ready = req_ready_q;
    assign data_byte        = data_byte_q;
    assign set_baud         = set_baud_q;
    assign grant_id         = grant_id_q;
    assign en_send          = en_send_q;
    assign busy             = busy_q;
    assign done_pulse       = done_q;
    assign err_timeout      = err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a behavioural uart_byte_tx model that
// rebuilds each frame from the live data_byte output.
`timescale 1ns/1ps
module tb_uart_tx_arb;
    localparam int N_REQ   = 4;
    localparam int GAP_CYC = 16;
    localparam int TO_W    = 6;
    localparam int TO_CYC  = 63;
    localparam int EV_RDY = 0, EV_EN = 1, EV_DONE = 2, EV_ERR = 3;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
        logic [2:0] baud;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(N_REQ)) req_if ();

    logic [7:0] data_byte;
    logic [2:0] set_baud, grant_id;
    logic en_send, tx_done, uart_state, busy, done_pulse, err_timeout;
    logic model_td = 1'b0, model_us = 1'b0, stray_td = 1'b0, stray_us = 1'b0, model_en = 1'b1;
    assign tx_done    = model_td | stray_td;
    assign uart_state = model_us | stray_us;

    uart_tx_arb #(.N_REQ(N_REQ), .GAP_CYC(GAP_CYC), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_if(req_if),
        .data_byte(data_byte), .set_baud(set_baud), .en_send(en_send),
        .tx_done(tx_done), .uart_state(uart_state), .busy(busy),
        .grant_id(grant_id), .done_pulse(done_pulse), .err_timeout(err_timeout)
    );

    txn_t exp_q[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int n_rdy = 0, n_en = 0, n_done = 0, n_err = 0, en_long = 0, n_frames = 0;
    int t_rdy = 0, t_en = 0, t_done = 0, t_err = 0, t_td = 0;
    logic [7:0] cur_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {req_if.req_ready, en_send, busy, done_pulse, err_timeout, data_byte, set_baud, grant_id};
    endfunction

    function automatic int cnt_of(input int which);
        case (which)
            EV_RDY:  return n_rdy;
            EV_EN:   return n_en;
            EV_DONE: return n_done;
            default: return n_err;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_for(input int which, input int target, input string name);
        int w = 0;
        while (cnt_of(which) < target && w < 1000) begin @(negedge clk); #1; w++; end
        if (cnt_of(which) < target) check(name, cnt_of(which), target);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] b);
        req_if.req_data[8*i +: 8] = d;
        req_if.req_baud[3*i +: 3] = b;
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [7:0] d, input logic [2:0] b);
        txn_t t;
        t.id = id; t.data = d; t.baud = b;
        exp_q.push_back(t);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on each en_send and stamps output events.
    initial begin : monitor
        txn_t e;
        logic en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_if.req_ready != '0) begin
                    n_rdy++;
                    t_rdy = cyc;
                    check("req_ready_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("req_ready_onehot", req_if.req_ready, 4'b0001 << exp_q[0].id);
                end
                if (en_send) begin
                    n_en++;
                    t_en = cyc;
                    if (en_prev) en_long++;
                    check("en_send_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        cur_data = e.data;
                        check("en_send_txn", {grant_id, data_byte, set_baud}, {e.id, e.data, e.baud});
                    end
                end
                if (done_pulse)  begin n_done++; t_done = cyc; end
                if (err_timeout) begin n_err++;  t_err  = cyc; end
            end
            en_prev = en_send;
        end
    end

    // uart_byte_tx model: 10-bit frame, bit period 2+set_baud clocks.
    initial begin : uart_model
        logic active = 1'b0;
        logic [7:0] cap_data = 8'h00, dec = 8'h00, mask = 8'h00;
        logic [2:0] cap_baud = 3'd0;
        int cnt = 0, bitper = 0, bitn = 0, bad = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0; model_us = 1'b0; model_td = 1'b0;
            end else begin
                model_td = 1'b0;
                if (active) begin
                    if (data_byte !== cap_data || set_baud !== cap_baud) bad++;
                    cnt++;
                    if (cnt == bitper) begin
                        cnt = 0;
                        if (bitn >= 1 && bitn <= 8) begin
                            dec  = dec | (data_byte & mask);
                            mask = mask << 1;
                        end
                        bitn++;
                        if (bitn == 10) begin
                            active = 1'b0; model_us = 1'b0; model_td = 1'b1;
                            t_td = cyc;
                            n_frames++;
                            check("frame_stable", bad, 0);
                            check("frame_decode", dec, cur_data);
                        end
                    end
                end else if (en_send && model_en) begin
                    active = 1'b1; model_us = 1'b1;
                    cap_data = data_byte; cap_baud = set_baud;
                    bitper = 2 + int'(set_baud);
                    cnt = 0; bitn = 0; bad = 0; dec = 8'h00; mask = 8'h01;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        req_if.req_baud  = '0;
        #2 rst_n = 1'b0;
        tick(3);
        check("reset_outputs", outs(), 22'd0);
        rst_n = 1'b1;
        tick(2);

        // Single requester, then grant spacing after the gap.
        set_req(2, 8'h0F, 3'd0);
        push_exp(3'd2, 8'h0F, 3'd0);
        req_if.req_valid = 4'b0100;
        wait_for(EV_RDY, 1, "t1_ready_wait");
        req_if.req_valid = '0;
        check("t1_grant_id", grant_id, 3'd2);
        check("t1_busy", busy, 1'b1);
        wait_for(EV_EN, 1, "t1_en_wait");
        check("t1_ready_to_en", t_en - t_rdy, 1);
        wait_for(EV_DONE, 1, "t1_done_wait");
        check("t1_done_after_tx_done", t_done - t_td, 1);
        set_req(3, 8'h55, 3'd1);
        push_exp(3'd3, 8'h55, 3'd1);
        req_if.req_valid = 4'b1000;
        wait_for(EV_RDY, 2, "t1_ready2_wait");
        req_if.req_valid = '0;
        check("t1_gap_spacing", t_rdy - t_done, GAP_CYC + 1);
        wait_for(EV_DONE, 2, "t1_done2_wait");

        // All four continuously valid: order 0,1,2,3,0.
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'hA0 + 8'(i), 3'd0);
        for (int i = 0; i < 5; i++) push_exp(3'(i % N_REQ), 8'hA0 + 8'(i % N_REQ), 3'd0);
        req_if.req_valid = 4'b1111;
        wait_for(EV_RDY, 7, "t2_ready_wait");
        req_if.req_valid = '0;
        wait_for(EV_DONE, 7, "t2_done_wait");

        // Per-requester baud codes.
        set_req(0, 8'hAA, 3'd1);
        set_req(1, 8'hEE, 3'd2);
        push_exp(3'd0, 8'hAA, 3'd1);
        push_exp(3'd1, 8'hEE, 3'd2);
        req_if.req_valid = 4'b0001;
        wait_for(EV_RDY, 8, "t3_ready0_wait");
        req_if.req_valid = 4'b0010;
        wait_for(EV_RDY, 9, "t3_ready1_wait");
        req_if.req_valid = '0;
        wait_for(EV_DONE, 9, "t3_done_wait");

        // Watchdog: no tx_done, next pending requester still served.
        model_en = 1'b0;
        set_req(2, 8'h3C, 3'd0);
        set_req(3, 8'h77, 3'd0);
        push_exp(3'd2, 8'h3C, 3'd0);
        push_exp(3'd3, 8'h77, 3'd0);
        req_if.req_valid = 4'b0100;
        wait_for(EV_RDY, 10, "t4_ready_wait");
        req_if.req_valid = 4'b1000;
        wait_for(EV_ERR, 1, "t4_err_wait");
        model_en = 1'b1;
        check("t4_timeout_latency", t_err - t_en, TO_CYC);
        check("t4_no_done", n_done, 9);
        wait_for(EV_RDY, 11, "t4_next_ready_wait");
        req_if.req_valid = '0;
        check("t4_next_grant", grant_id, 3'd3);
        wait_for(EV_DONE, 10, "t4_done_wait");

        // Asynchronous reset in the middle of a frame.
        set_req(0, 8'h81, 3'd0);
        push_exp(3'd0, 8'h81, 3'd0);
        req_if.req_valid = 4'b0001;
        wait_for(EV_RDY, 12, "t5_ready_wait");
        req_if.req_valid = '0;
        wait_for(EV_EN, 12, "t5_en_wait");
        tick(5);
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", outs(), 22'd0);
        tick(3);
        rst_n = 1'b1;
        set_req(0, 8'h11, 3'd0);
        set_req(3, 8'h33, 3'd0);
        push_exp(3'd0, 8'h11, 3'd0);
        push_exp(3'd3, 8'h33, 3'd0);
        req_if.req_valid = 4'b1001;
        wait_for(EV_RDY, 13, "t5_ready0_wait");
        req_if.req_valid = 4'b1000;
        wait_for(EV_RDY, 14, "t5_ready3_wait");
        req_if.req_valid = '0;
        wait_for(EV_DONE, 12, "t5_done_wait");

        // Stray tx_done in GAP and IDLE, request withdrawn before grant.
        set_req(2, 8'h5A, 3'd0);
        push_exp(3'd2, 8'h5A, 3'd0);
        req_if.req_valid = 4'b0100;
        wait_for(EV_RDY, 15, "t6_ready_wait");
        req_if.req_valid = '0;
        wait_for(EV_DONE, 13, "t6_done_wait");
        stray_td = 1'b1;
        tick(1);
        stray_td = 1'b0;
        req_if.req_valid = 4'b0010;
        tick(5);
        req_if.req_valid = '0;
        tick(20);
        check("t6_gap_stray_no_done", n_done, 13);
        check("t6_withdrawn_no_ready", n_rdy, 15);
        check("t6_withdrawn_no_en", n_en, 15);
        check("t6_back_idle", busy, 1'b0);
        stray_td = 1'b1;
        tick(1);
        stray_td = 1'b0;
        tick(3);
        check("t6_idle_stray_no_done", n_done, 13);
        check("t6_idle_stray_no_busy", busy, 1'b0);

        // Foreign UART activity holds off the grant.
        stray_us = 1'b1;
        set_req(0, 8'hC3, 3'd3);
        req_if.req_valid = 4'b0001;
        tick(6);
        check("t6_foreign_no_grant", n_rdy, 15);
        push_exp(3'd0, 8'hC3, 3'd3);
        stray_us = 1'b0;
        wait_for(EV_RDY, 16, "t6_foreign_ready_wait");
        req_if.req_valid = '0;
        wait_for(EV_DONE, 14, "t6_foreign_done_wait");

        tick(4);
        check("final_en_count", n_en, 16);
        check("final_done_count", n_done, 14);
        check("final_err_count", n_err, 1);
        check("final_frames", n_frames, 14);
        check("en_send_single_cycle", en_long, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
